ysyx_23060042_wbu: RTL and testbench
====================================

Name: ysyx_23060042_wbu

Overview:
Writeback unit and general-purpose register file for the NPC core. It receives the execute stage's result (wdata, destination rd, write enable) through a valid/ready handshake, buffers it in a small in-order queue, and retires one entry per cycle into a 32x32 register file. It also drives the execute stage's rdata1/rdata2 operand ports, with bypass from pending queue entries so operands are never stale.

Parameters:
XLEN, 32, data width of registers and wdata
NREG_BITS, 5, register address width (2^5 = 32 registers, x0 hardwired zero)
QDEPTH, 2, pending-writeback queue depth (power of two, >= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  execute result valid
in_ready  output  1  queue can accept an entry
in_rd  input  NREG_BITS  destination register
in_wdata  input  XLEN  result data
in_wen  input  1  register write requested
wb_stall  input  1  hold retirement (debug/difftest pause)
raddr1  input  NREG_BITS  operand 1 read address
raddr2  input  NREG_BITS  operand 2 read address
rdata1  output  XLEN  operand 1 data (combinational)
rdata2  output  XLEN  operand 2 data (combinational)
commit_valid  output  1  one-cycle pulse per retired entry (registered)
commit_rd  output  NREG_BITS  rd of retired entry
commit_wdata  output  XLEN  data of retired entry
commit_wen  output  1  effective write happened (in_wen and rd != 0)
pending  output  1  queue non-empty

Behaviour:
- Reset (rst high at a clock edge): all 32 registers := 0; queue empty (head=tail=count=0); commit_valid=0, commit_rd=0, commit_wdata=0, commit_wen=0. Reset mid-operation discards queued entries without writing them.
- in_ready = (count < QDEPTH); registered-state only, no combinational path from in_valid.
- Push: in_valid && in_ready at edge -> enqueue {rd, wdata, wen} at tail. Entries with in_wen=0 are still enqueued (they occupy a slot and produce a commit pulse).
- Pop: count > 0 && !wb_stall at edge -> dequeue head; if wen && rd != 0, reg[rd] := wdata. rd=0 writes discarded.
- Simultaneous push and pop: count unchanged, both pointers advance. Push while full is impossible (in_ready=0); in_valid is ignored.
- Pointers wrap modulo QDEPTH.
- Latency: entry accepted at edge ending cycle N is at head in N+1; with no stall it is retired at the edge ending N+1; register file shows the value from N+2; commit_valid=1 during N+2 only, carrying that entry's rd/wdata/wen (commit_wen = wen && rd != 0).
- commit_valid is 0 in any cycle following an edge with no pop (including stall cycles).
- Read ports: rdata = 0 if raddr == 0; else the wdata of the youngest queued entry with wen=1 and rd == raddr; else reg[raddr]. Bypass does not include the same-cycle in_* input.
- pending = (count != 0).
- wb_stall held: queue fills to QDEPTH, in_ready drops, bypass keeps serving queued values; on release, retirement resumes at one per cycle in order.

Test Plan:
- Reset: after rst, read raddr1=5, raddr2=31 -> rdata1=0, rdata2=0, in_ready=1, pending=0, commit_valid=0.
- Single write: push rd=3, wdata=0xDEADBEEF, wen=1 in cycle N -> rdata1(raddr1=3)=0xDEADBEEF from N+1 (bypass) onward; commit_valid=1, commit_rd=3, commit_wen=1 in N+2 only.
- x0 and wen=0: push rd=0 wdata=0x1234 wen=1, then rd=7 wdata=0x55 wen=0 -> reads of x0 and x7 stay 0; two commit pulses with commit_wen=0.
- Bypass priority: with wb_stall=1 push rd=4 wdata=1 then rd=4 wdata=2 -> count=2, in_ready=0, rdata(4)=2; release stall -> commits of 1 then 2 on consecutive cycles, final reg[4]=2.
- Back-to-back streaming: in_valid held 10 cycles, rd=1..10, wdata=rd*0x10, no stall -> in_ready stays 1, 10 consecutive commit pulses in order, reg[k]=k*0x10.
- Reset mid-flight: stall, fill queue with rd=9 wdata=0xAA, assert rst -> no commit pulse, reg[9]=0, count=0, in_ready=1.

Source files
------------

// File: rtl/ysyx_23060042_wbu.sv
// Writeback unit: in-order pending-writeback queue retiring into a 32-entry GPR file,
// with operand read ports that bypass from queued (not yet retired) results.
module ysyx_23060042_wbu #(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5,
    parameter int QDEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NREG_BITS-1:0] in_rd,
    input  logic [XLEN-1:0]      in_wdata,
    input  logic                 in_wen,
    input  logic                 wb_stall,
    input  logic [NREG_BITS-1:0] raddr1,
    input  logic [NREG_BITS-1:0] raddr2,
    output logic [XLEN-1:0]      rdata1,
    output logic [XLEN-1:0]      rdata2,
    output logic                 commit_valid,
    output logic [NREG_BITS-1:0] commit_rd,
    output logic [XLEN-1:0]      commit_wdata,
    output logic                 commit_wen,
    output logic                 pending
);

    localparam int NREG = 1 << NREG_BITS;
    localparam int PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNTW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0]      r_regs    [NREG];
    logic [NREG_BITS-1:0] r_q_rd    [QDEPTH];
    logic [XLEN-1:0]      r_q_wdata [QDEPTH];
    logic                 r_q_wen   [QDEPTH];
    logic [PTRW-1:0]      r_head;
    logic [PTRW-1:0]      r_tail;
    logic [CNTW-1:0]      r_count;

    logic w_push;
    logic w_pop;
    logic w_head_wr;

    assign in_ready  = (r_count < CNTW'(QDEPTH));
    assign pending   = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = (r_count != '0) && !wb_stall;
    assign w_head_wr = r_q_wen[r_head] && (r_q_rd[r_head] != '0);

    // Queue payload carries no reset; occupancy is governed solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_tail]    <= in_rd;
            r_q_wdata[r_tail] <= in_wdata;
            r_q_wen[r_tail]   <= in_wen;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_wdata <= '0;
            commit_wen   <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
                if (w_head_wr) begin
                    r_regs[r_q_rd[r_head]] <= r_q_wdata[r_head];
                end
                commit_rd    <= r_q_rd[r_head];
                commit_wdata <= r_q_wdata[r_head];
                commit_wen   <= w_head_wr;
            end
            commit_valid <= w_pop;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Walk queued entries oldest to youngest so the youngest matching write wins.
    function automatic logic [XLEN-1:0] f_read(input logic [NREG_BITS-1:0] addr);
        logic [XLEN-1:0] v;
        logic [PTRW-1:0] idx;
        v = r_regs[addr];
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            idx = r_head + PTRW'(i);
            if ((CNTW'(i) < r_count) && r_q_wen[idx] && (r_q_rd[idx] == addr)) begin
                v = r_q_wdata[idx];
            end
        end
        if (addr == '0) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rdata1 = f_read(raddr1);
        rdata2 = f_read(raddr2);
    end

endmodule

// File: tb/tb_ysyx_23060042_wbu.sv
// Bench for ysyx_23060042_wbu: scoreboard of expected commits plus direct
// checks of read ports, handshake and pulse timing.
module tb_ysyx_23060042_wbu;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        wen;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_wdata;
    logic        in_wen;
    logic        wb_stall;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_wdata;
    logic        commit_wen;
    logic        pending;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_commits = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    ysyx_23060042_wbu #(.XLEN(32), .NREG_BITS(5), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_wdata(in_wdata), .in_wen(in_wen), .wb_stall(wb_stall),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_wdata(commit_wdata), .commit_wen(commit_wen), .pending(pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one entry for a single edge; caller guarantees the queue has room.
    task automatic push_one(input logic [4:0] rd, input logic [31:0] wd, input logic wen);
        in_valid = 1'b1;
        in_rd    = rd;
        in_wdata = wd;
        in_wen   = wen;
        check("push_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back('{rd: rd, wdata: wd, wen: wen});
        step();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (!rst && commit_valid) begin
            n_commits++;
            if (sb.size() == 0) begin
                check("spurious_commit", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("commit_rd", {27'd0, commit_rd}, {27'd0, e.rd});
                check("commit_wdata", commit_wdata, e.wdata);
                check("commit_wen", {31'd0, commit_wen}, {31'd0, (e.wen && e.rd != 5'd0)});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_wdata = '0; in_wen = 1'b0;
        wb_stall = 1'b0; raddr1 = '0; raddr2 = '0;
        step(); step();
        rst = 1'b0;

        // reset state
        raddr1 = 5'd5; raddr2 = 5'd31;
        #1;
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_rdata2", rdata2, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_pending", {31'd0, pending}, 32'd0);
        check("rst_commit", {31'd0, commit_valid}, 32'd0);

        // single write: bypass in N+1, commit pulse in N+2 only
        raddr1 = 5'd3;
        push_one(5'd3, 32'hDEADBEEF, 1'b1);
        #1;
        check("sw_bypass", rdata1, 32'hDEADBEEF);
        check("sw_n1_commit", {31'd0, commit_valid}, 32'd0);
        check("sw_n1_pending", {31'd0, pending}, 32'd1);
        step();
        check("sw_n2_commit", {31'd0, commit_valid}, 32'd1);
        check("sw_n2_rd", {27'd0, commit_rd}, 32'd3);
        check("sw_n2_wen", {31'd0, commit_wen}, 32'd1);
        check("sw_n2_rf", rdata1, 32'hDEADBEEF);
        check("sw_n2_pending", {31'd0, pending}, 32'd0);
        step();
        check("sw_n3_commit", {31'd0, commit_valid}, 32'd0);
        check("sw_n3_rf", rdata1, 32'hDEADBEEF);

        // x0 write and wen=0 entry
        raddr1 = 5'd0; raddr2 = 5'd7;
        push_one(5'd0, 32'h1234, 1'b1);
        #1;
        check("x0_bypass", rdata1, 32'd0);
        push_one(5'd7, 32'h55, 1'b0);
        #1;
        check("nowen_bypass", rdata2, 32'd0);
        step(); step();
        check("x0_rf", rdata1, 32'd0);
        check("x7_rf", rdata2, 32'd0);

        // bypass priority under stall, then ordered drain
        wb_stall = 1'b1; raddr1 = 5'd4;
        push_one(5'd4, 32'd1, 1'b1);
        #1;
        check("bp_first", rdata1, 32'd1);
        push_one(5'd4, 32'd2, 1'b1);
        #1;
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        check("bp_full_pending", {31'd0, pending}, 32'd1);
        check("bp_youngest", rdata1, 32'd2);
        check("bp_stall_commit", {31'd0, commit_valid}, 32'd0);
        in_valid = 1'b1; in_rd = 5'd4; in_wdata = 32'd99; in_wen = 1'b1;
        step(); step();
        check("bp_ignored_ready", {31'd0, in_ready}, 32'd0);
        check("bp_ignored_data", rdata1, 32'd2);
        check("bp_stall_commit2", {31'd0, commit_valid}, 32'd0);
        in_valid = 1'b0;
        wb_stall = 1'b0;
        step();
        check("bp_rel1_commit", {31'd0, commit_valid}, 32'd1);
        check("bp_rel1_data", commit_wdata, 32'd1);
        check("bp_rel1_ready", {31'd0, in_ready}, 32'd1);
        check("bp_rel1_read", rdata1, 32'd2);
        step();
        check("bp_rel2_commit", {31'd0, commit_valid}, 32'd1);
        check("bp_rel2_data", commit_wdata, 32'd2);
        step();
        check("bp_done_commit", {31'd0, commit_valid}, 32'd0);
        check("bp_final_rf", rdata1, 32'd2);
        check("bp_final_pending", {31'd0, pending}, 32'd0);

        // back-to-back streaming
        c0 = n_commits;
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1; in_rd = 5'(k); in_wdata = 32'(k * 16); in_wen = 1'b1;
            check("stream_ready", {31'd0, in_ready}, 32'd1);
            sb.push_back('{rd: 5'(k), wdata: 32'(k * 16), wen: 1'b1});
            step();
            if (k > 1) check("stream_commit", {31'd0, commit_valid}, 32'd1);
        end
        in_valid = 1'b0;
        step(); step();
        check("stream_count", 32'(n_commits - c0), 32'd10);
        check("stream_sb_empty", 32'(sb.size()), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            raddr1 = 5'(k);
            #1;
            check("stream_rf", rdata1, 32'(k * 16));
        end

        // reset mid-flight discards queued entries
        step();
        wb_stall = 1'b1; raddr1 = 5'd9;
        push_one(5'd9, 32'hAA, 1'b1);
        push_one(5'd9, 32'hAA, 1'b1);
        #1;
        check("mf_full_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        wb_stall = 1'b0;
        check("mf_pending", {31'd0, pending}, 32'd0);
        check("mf_ready", {31'd0, in_ready}, 32'd1);
        check("mf_commit", {31'd0, commit_valid}, 32'd0);
        check("mf_read", rdata1, 32'd0);
        step(); step();
        check("mf_commit_late", {31'd0, commit_valid}, 32'd0);
        check("mf_rf", rdata1, 32'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
